serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that time-multiplexes one 1-bit full-adder slice over a WIDTH-bit operation. The slice is built from two half-adder cells plus an OR gate. The block latches two operands on a start request and feeds them LSB-first through the slice, one bit per clock, while holding the running carry in a flop. It then presents the assembled sum and carry-out with a one-cycle done pulse. It is the sequencing layer the team uses in place of a WIDTH-wide ripple adder when area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 177 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders + OR) sequenced LSB-first over WIDTH bits.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.

module serial_adder_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s1;
   logic c1;
   logic c2;

   serial_adder_ha u_ha1 (.x(x),  .y(y),  .s(s1), .c(c1));
   serial_adder_ha u_ha2 (.x(s1), .y(ci), .s(s),  .c(c2));

   assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] sum_next;
   logic             carry_q;
   logic             carry_next;
   logic             cout_next;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_next;
   logic             busy_next;
   logic             done_next;

   logic             bit_c;
   logic             carry_c;
   logic [WIDTH-1:0] b_load_c;
   logic             carry_init_c;

   // Subtraction is a + ~b + 1: invert B at capture and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load_c     = sub ? ~b : b;
   assign carry_init_c = sub;
`else
   assign b_load_c     = b;
   assign carry_init_c = 1'b0;
`endif

   serial_adder_fa u_slice (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .ci (carry_q),
      .s  (bit_c),
      .co (carry_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      state_next = state;
      a_next     = a_q;
      b_next     = b_q;
      res_next   = res_q;
      carry_next = carry_q;
      count_next = count_q;
      sum_next   = sum;
      cout_next  = cout;

      case (state)
         IDLE: begin
            if (start) begin
               a_next     = a;
               b_next     = b_load_c;
               carry_next = carry_init_c;
               count_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            a_next     = a_q >> 1;
            b_next     = b_q >> 1;
            carry_next = carry_c;
            res_next   = (res_q >> 1) | (WIDTH'(bit_c) << (WIDTH - 1));
            count_next = count_q + CNT_W'(1);
            // Last bit: publish the result including the bit formed on this edge.
            if (count_q == LAST_BIT) begin
               sum_next   = res_next;
               cout_next  = carry_c;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   // Datapath and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         a_q     <= a_next;
         b_q     <= b_next;
         res_q   <= res_next;
         carry_q <= carry_next;
         count_q <= count_next;
         sum     <= sum_next;
         cout    <= cout_next;
         busy    <= busy_next;
         done    <= done_next;
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1; subtract cases run when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic         start1;
   logic         a1;
   logic         b1;
   logic         busy1;
   logic         done1;
   logic         sum1;
   logic         cout1;

`ifdef SERIAL_ADDER_SUB_EN
   logic         sub_v;
   logic         sub1;
`endif

   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] last_sum = '0;
   logic [W:0]   sb_q[$];
   logic [1:0]   sb1_q[$];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub_v),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub1),
`endif
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   // Reference: {cout, sum} of a + b, or a + ~b + 1 when subtracting.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W-1:0] yy;
      yy = s ? ~y : y;
      return {1'b0, x} + {1'b0, yy} + (W+1)'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int         cyc;
      int         busy_cyc;
      int         hold_bad;
      logic [W:0] exp_r;
      a     = x;
      b     = y;
`ifdef SERIAL_ADDER_SUB_EN
      sub_v = s;
`endif
      start = 1'b1;
      sb_q.push_back(model(x, y, s));
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cyc = 0; busy_cyc = 0; hold_bad = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cyc++;
         if (sum !== last_sum) hold_bad++;
         tick();
         cyc++;
      end
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL op_timeout: no done within %0d cycles (a=%h b=%h)", cyc, x, y);
      end
      tests++;
      if (cyc != W) begin
         fails++;
         $display("FAIL op_latency: done after %0d cycles, required %0d", cyc, W);
      end
      tests++;
      if (busy_cyc != W) begin
         fails++;
         $display("FAIL op_busy_cycles: busy for %0d cycles, required %0d", busy_cyc, W);
      end
      tests++;
      if (hold_bad != 0) begin
         fails++;
         $display("FAIL op_sum_hold: sum changed during RUN in %0d cycles, required %h", hold_bad, last_sum);
      end
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $display("FAIL op_scoreboard: nothing expected");
      end else begin
         exp_r = sb_q.pop_front();
         if ({cout, sum} !== exp_r) begin
            fails++;
            $display("FAIL op_result a=%h b=%h sub=%0b: got cout=%b sum=%h, required cout=%b sum=%h",
                     x, y, s, cout, sum, exp_r[W], exp_r[W-1:0]);
         end
         last_sum = exp_r[W-1:0];
      end
      sb_q.delete();
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL op_done_pulse: after DONE got done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_v = 1'b0; sub1 = 1'b0;
`endif
      #12;
      tests++;
      if ({busy, done, cout, sum} !== '0) begin
         fails++;
         $display("FAIL reset_w8: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
      end
      tests++;
      if ({busy1, done1, cout1, sum1} !== 4'b0) begin
         fails++;
         $display("FAIL reset_w1: busy=%b done=%b cout=%b sum=%b, required all 0", busy1, done1, cout1, sum1);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      run_op(8'h05, 8'h03, 1'b0);
   endtask

   task automatic test_wrap();
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hAA, 8'h55, 1'b0);
   endtask

   task automatic test_ignore_start();
      int         pulses;
      logic [W:0] exp_r;
      a = 8'h10; b = 8'h20; start = 1'b1;
      sb_q.push_back(model(8'h10, 8'h20, 1'b0));
      tick();
      pulses = 0;
      for (int cyc = 0; cyc < int'(W) + 8; cyc++) begin
         if (done) begin
            pulses++;
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL ignore_extra_done: unexpected done, sum=%h", sum);
            end else begin
               exp_r = sb_q.pop_front();
               if ({cout, sum} !== exp_r) begin
                  fails++;
                  $display("FAIL ignore_result: got cout=%b sum=%h, required cout=%b sum=%h",
                           cout, sum, exp_r[W], exp_r[W-1:0]);
               end
               last_sum = exp_r[W-1:0];
            end
         end
         start = busy || done;
         a = (cyc % 2 == 0) ? 8'hFF : W'($urandom);
         b = (cyc % 2 == 0) ? 8'hFF : W'($urandom);
         tick();
      end
      start = 1'b0;
      tests++;
      if (pulses != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ignore_pulses: got %0d done pulses busy=%b, required 1 and 0", pulses, busy);
      end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      a = 8'h33; b = 8'h44; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({busy, done, cout, sum} !== '0) begin
         fails++;
         $display("FAIL reset_mid_run: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
      end
      tick();
      rst = 1'b0;
      last_sum = '0;
      pulses = 0;
      repeat (15) begin
         if (done) pulses++;
         tick();
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL reset_no_done: got %0d done pulses after abort, required 0", pulses);
      end
      run_op(8'h7F, 8'h01, 1'b0);
   endtask

   task automatic test_back_to_back();
      int         ndone;
      int         dcyc[3];
      logic [W:0] exp_r;
      a = 8'h01; b = 8'h01; start = 1'b1;
      ndone = 0;
      for (int cyc = 0; cyc < 60 && ndone < 3; cyc++) begin
         if (done) begin
            dcyc[ndone] = cyc;
            ndone++;
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL b2b_extra_done: unexpected done at cycle %0d", cyc);
            end else begin
               exp_r = sb_q.pop_front();
               if ({cout, sum} !== exp_r) begin
                  fails++;
                  $display("FAIL b2b_result: got cout=%b sum=%h, required cout=%b sum=%h",
                           cout, sum, exp_r[W], exp_r[W-1:0]);
               end
            end
            if (ndone == 3) start = 1'b0;
         end else if (!busy && start) begin
            sb_q.push_back(model(a, b, 1'b0));
         end
         tick();
      end
      start = 1'b0;
      tests++;
      if (ndone != 3) begin
         fails++;
         $display("FAIL b2b_count: got %0d done pulses, required 3", ndone);
      end else begin
         tests++;
         if (dcyc[1] - dcyc[0] != int'(W) + 2 || dcyc[2] - dcyc[1] != int'(W) + 2) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d and %0d, required %0d", dcyc[1] - dcyc[0],
                     dcyc[2] - dcyc[1], W + 2);
         end
      end
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
      end
      last_sum = 8'h02;
      sb_q.delete();
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), 1'b0);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      run_op(8'h05, 8'h07, 1'b1);
      run_op(8'h07, 8'h05, 1'b1);
      run_op(8'h05, 8'h07, 1'b0);
   endtask
`endif

   task automatic test_width1();
      int         cyc;
      logic [1:0] exp_r;
      for (int i = 0; i < 4; i++) begin
         a1 = 1'(i >> 1);
         b1 = 1'(i);
         start1 = 1'b1;
         sb1_q.push_back(2'(a1) + 2'(b1));
         tick();
         start1 = 1'b0;
         a1 = ~a1;
         b1 = ~b1;
         cyc = 0;
         while (!done1 && cyc < 10) begin
            tick();
            cyc++;
         end
         tests++;
         if (cyc != 1 || done1 !== 1'b1) begin
            fails++;
            $display("FAIL w1_latency case %0d: done after %0d cycles (done=%b), required 1", i, cyc, done1);
         end
         tests++;
         exp_r = (sb1_q.size() > 0) ? sb1_q.pop_front() : 2'bxx;
         if ({cout1, sum1} !== exp_r) begin
            fails++;
            $display("FAIL w1_result case %0d: got cout=%b sum=%b, required %b", i, cout1, sum1, exp_r);
         end
         sb1_q.delete();
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_width1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
